// File: rtl/writeback_unit.sv
`default_nettype none
// ==========================================================================
// writeback_unit : WB pipeline register, load extraction, RF write port
// Rev 1.0
// ==========================================================================
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_reg_wr,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_byte_off,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              wb_valid,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic              wb_wr_flag;
  logic [1:0]        wb_sel;
  logic [2:0]        wb_load_type;
  logic [1:0]        wb_off;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_rd_data;
  logic [DATA_W-1:0] wb_link;

  logic              capture;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] load_val;
  logic              misaligned;

  // A stalled edge neither consumes nor counts the upstream instruction.
  assign capture = mem_valid & ~wb_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_wr_flag   <= 1'b0;
      wb_sel       <= 2'b00;
      wb_load_type <= 3'b000;
      wb_off       <= 2'b00;
      wb_dest      <= '0;
      wb_alu       <= '0;
      wb_rd_data   <= '0;
      wb_link      <= '0;
      retire_count <= '0;
    end else if (!wb_stall) begin
      wb_valid     <= capture;
      wb_wr_flag   <= mem_reg_wr;
      wb_sel       <= mem_wb_sel;
      wb_load_type <= mem_load_type;
      wb_off       <= mem_byte_off;
      wb_dest      <= mem_dest;
      wb_alu       <= mem_alu_result;
      wb_rd_data   <= mem_rd_data;
      wb_link      <= mem_pc_plus4;
      if (capture) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    byte_val = wb_rd_data[7:0];
    case (wb_off)
      2'd1:    byte_val = wb_rd_data[15:8];
      2'd2:    byte_val = wb_rd_data[23:16];
      2'd3:    byte_val = wb_rd_data[31:24];
      default: byte_val = wb_rd_data[7:0];
    endcase
    half_val = wb_off[1] ? wb_rd_data[31:16] : wb_rd_data[15:0];
  end

  // Unknown load codes fall back to lw, including the alignment rule.
  always_comb begin
    load_val   = wb_rd_data;
    misaligned = (wb_off != 2'b00);
    case (wb_load_type)
      LT_LB: begin
        load_val   = {{(DATA_W-8){byte_val[7]}}, byte_val};
        misaligned = 1'b0;
      end
      LT_LBU: begin
        load_val   = {{(DATA_W-8){1'b0}}, byte_val};
        misaligned = 1'b0;
      end
      LT_LH: begin
        load_val   = {{(DATA_W-16){half_val[15]}}, half_val};
        misaligned = wb_off[0];
      end
      LT_LHU: begin
        load_val   = {{(DATA_W-16){1'b0}}, half_val};
        misaligned = wb_off[0];
      end
      default: begin
        load_val   = wb_rd_data;
        misaligned = (wb_off != 2'b00);
      end
    endcase
  end

  always_comb begin
    reg_wr_data = wb_alu;
    case (wb_sel)
      SEL_LOAD: reg_wr_data = load_val;
      SEL_LINK: reg_wr_data = wb_link;
      default:  reg_wr_data = wb_alu;
    endcase
  end

  assign misalign_err = wb_valid & (wb_sel == SEL_LOAD) & misaligned;
  assign reg_wr       = wb_valid & wb_wr_flag & (wb_dest != '0) & ~misalign_err;
  assign reg_wr_addr  = wb_dest;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ==========================================================================
// tb_writeback_unit : directed self-checking bench for writeback_unit
// Rev 1.0
// ==========================================================================
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_reg_wr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_byte_off;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_rd_data, mem_pc_plus4;
  logic        wb_stall, wb_flush;

  logic        reg_wr, wb_valid, misalign_err;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data, retire_count;

  logic        reg_wr4, wb_valid4, misalign_err4;
  logic [4:0]  reg_wr_addr4;
  logic [31:0] reg_wr_data4;
  logic [3:0]  retire_count4;

  int ncmp  = 0;
  int nfail = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_reg_wr(mem_reg_wr),
    .mem_wb_sel(mem_wb_sel), .mem_load_type(mem_load_type), .mem_byte_off(mem_byte_off),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_rd_data(mem_rd_data),
    .mem_pc_plus4(mem_pc_plus4), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .wb_valid(wb_valid), .misalign_err(misalign_err), .retire_count(retire_count)
  );

  // Narrow-counter instance shares all stimulus; used for the wrap check.
  writeback_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_reg_wr(mem_reg_wr),
    .mem_wb_sel(mem_wb_sel), .mem_load_type(mem_load_type), .mem_byte_off(mem_byte_off),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_rd_data(mem_rd_data),
    .mem_pc_plus4(mem_pc_plus4), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .reg_wr(reg_wr4), .reg_wr_addr(reg_wr_addr4), .reg_wr_data(reg_wr_data4),
    .wb_valid(wb_valid4), .misalign_err(misalign_err4), .retire_count(retire_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
    mem_valid = v; mem_reg_wr = wr; mem_wb_sel = sel; mem_load_type = lt;
    mem_byte_off = off; mem_dest = dest; mem_alu_result = alu;
    mem_rd_data = rd; mem_pc_plus4 = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 5'd3, 32'h1234, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      ncmp++; if (reg_wr !== 1'b0) begin nfail++; $display("FAIL reset_reg_wr[%0d] got=%0b exp=0", i, reg_wr); end
      ncmp++; if (wb_valid !== 1'b0) begin nfail++; $display("FAIL reset_wb_valid[%0d] got=%0b exp=0", i, wb_valid); end
      ncmp++; if (retire_count !== 32'd0) begin nfail++; $display("FAIL reset_count[%0d] got=%0d exp=0", i, retire_count); end
      ncmp++; if (reg_wr_addr !== 5'd0 || reg_wr_data !== 32'd0) begin nfail++; $display("FAIL reset_addr_data[%0d] got=%0h/%0h exp=0/0", i, reg_wr_addr, reg_wr_data); end
      ncmp++; if (misalign_err !== 1'b0 || retire_count4 !== 4'd0) begin nfail++; $display("FAIL reset_err_cnt4[%0d] got=%0b/%0d exp=0/0", i, misalign_err, retire_count4); end
    end
    reset = 1'b0;
    mem_valid = 1'b0;
    tick();
    ncmp++; if (reg_wr !== 1'b0 || wb_valid !== 1'b0) begin nfail++; $display("FAIL post_reset_idle got=%0b/%0b exp=0/0", reg_wr, wb_valid); end
    ncmp++; if (retire_count !== 32'd0) begin nfail++; $display("FAIL post_reset_count got=%0d exp=0", retire_count); end
    exp_cnt = 0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 5'd7, 32'd20, 32'hDEAD_BEEF, 32'h100);
    tick(); exp_cnt++;
    mem_valid = 1'b0;
    ncmp++; if (reg_wr !== 1'b1) begin nfail++; $display("FAIL alu_reg_wr got=%0b exp=1", reg_wr); end
    ncmp++; if (reg_wr_addr !== 5'd7) begin nfail++; $display("FAIL alu_addr got=%0d exp=7", reg_wr_addr); end
    ncmp++; if (reg_wr_data !== 32'd20) begin nfail++; $display("FAIL alu_data got=%0h exp=14", reg_wr_data); end
    ncmp++; if (retire_count !== 32'd1) begin nfail++; $display("FAIL alu_count got=%0d exp=1", retire_count); end
    tick();
    ncmp++; if (reg_wr !== 1'b0 || wb_valid !== 1'b0) begin nfail++; $display("FAIL alu_bubble got=%0b/%0b exp=0/0", reg_wr, wb_valid); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  lt  [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b111, 3'b010};
    logic [1:0]  off [7] = '{2'd1,   2'd3,   2'd2,   2'd0,   2'd0,   2'd0,   2'd2};
    logic [31:0] exp [7] = '{32'hFFFF_FFF2, 32'h0000_0080, 32'hFFFF_8081,
                             32'h0000_F2F3, 32'h8081_F2F3, 32'h8081_F2F3, 32'h0000_0081};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 2'b01, lt[i], off[i], 5'd4, 32'h0BAD_0BAD, 32'h8081_F2F3, 32'h44);
      tick(); exp_cnt++;
      ncmp++; if (reg_wr_data !== exp[i]) begin nfail++; $display("FAIL load_data[%0d] got=%0h exp=%0h", i, reg_wr_data, exp[i]); end
      ncmp++; if (reg_wr !== 1'b1 || misalign_err !== 1'b0 || reg_wr_addr !== 5'd4) begin nfail++; $display("FAIL load_wr[%0d] got=%0b/%0b/%0d exp=1/0/4", i, reg_wr, misalign_err, reg_wr_addr); end
    end
    ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL load_count got=%0d exp=%0d", retire_count, exp_cnt); end
  endtask

  task automatic test_link_and_sel3();
    drive(1'b1, 1'b1, 2'b10, 3'b000, 2'b11, 5'd31, 32'h1111, 32'h2222, 32'h0000_4008);
    tick(); exp_cnt++;
    ncmp++; if (reg_wr_data !== 32'h0000_4008 || reg_wr !== 1'b1 || misalign_err !== 1'b0) begin nfail++; $display("FAIL link got=%0h/%0b/%0b exp=4008/1/0", reg_wr_data, reg_wr, misalign_err); end
    drive(1'b1, 1'b1, 2'b11, 3'b011, 2'b01, 5'd2, 32'hCAFE_0001, 32'h2222, 32'h3333);
    tick(); exp_cnt++;
    ncmp++; if (reg_wr_data !== 32'hCAFE_0001 || reg_wr !== 1'b1 || misalign_err !== 1'b0) begin nfail++; $display("FAIL sel3_as_alu got=%0h/%0b/%0b exp=cafe0001/1/0", reg_wr_data, reg_wr, misalign_err); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 2'b01, 3'b011, 2'd1, 5'd5, 32'h0, 32'h8081_F2F3, 32'h0);
    tick(); exp_cnt++;
    ncmp++; if (misalign_err !== 1'b1 || reg_wr !== 1'b0) begin nfail++; $display("FAIL mis_lh got err/wr=%0b/%0b exp=1/0", misalign_err, reg_wr); end
    ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL mis_count got=%0d exp=%0d", retire_count, exp_cnt); end
    drive(1'b1, 1'b1, 2'b01, 3'b000, 2'd2, 5'd6, 32'h0, 32'h8081_F2F3, 32'h0);
    tick(); exp_cnt++;
    ncmp++; if (misalign_err !== 1'b1 || reg_wr !== 1'b0) begin nfail++; $display("FAIL mis_lw got err/wr=%0b/%0b exp=1/0", misalign_err, reg_wr); end
    drive(1'b1, 1'b1, 2'b01, 3'b001, 2'd3, 5'd6, 32'h0, 32'h8081_F2F3, 32'h0);
    tick(); exp_cnt++;
    ncmp++; if (misalign_err !== 1'b0 || reg_wr !== 1'b1) begin nfail++; $display("FAIL lb_off3_ok got err/wr=%0b/%0b exp=0/1", misalign_err, reg_wr); end
    drive(1'b1, 1'b1, 2'b00, 3'b000, 2'd1, 5'd0, 32'h77, 32'h0, 32'h0);
    tick(); exp_cnt++;
    ncmp++; if (reg_wr !== 1'b0 || misalign_err !== 1'b0 || wb_valid !== 1'b1) begin nfail++; $display("FAIL r0_write got wr/err/valid=%0b/%0b/%0b exp=0/0/1", reg_wr, misalign_err, wb_valid); end
    ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL r0_count got=%0d exp=%0d", retire_count, exp_cnt); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 5'd9, 32'h55, 32'h0, 32'h0);
    tick(); exp_cnt++;
    ncmp++; if (reg_wr_addr !== 5'd9 || reg_wr_data !== 32'h55 || reg_wr !== 1'b1) begin nfail++; $display("FAIL stall_capture got=%0d/%0h/%0b exp=9/55/1", reg_wr_addr, reg_wr_data, reg_wr); end
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b10, 3'b000, 2'b00, 5'(12 + i), 32'hAA + i, 32'h0, 32'h900 + i);
      tick();
      ncmp++; if (reg_wr_addr !== 5'd9 || reg_wr_data !== 32'h55 || reg_wr !== 1'b1) begin nfail++; $display("FAIL stall_hold[%0d] got=%0d/%0h/%0b exp=9/55/1", i, reg_wr_addr, reg_wr_data, reg_wr); end
      ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL stall_count[%0d] got=%0d exp=%0d", i, retire_count, exp_cnt); end
    end
    wb_flush = 1'b1;
    tick();
    ncmp++; if (wb_valid !== 1'b1 || reg_wr !== 1'b1 || reg_wr_data !== 32'h55) begin nfail++; $display("FAIL stall_flush_hold got=%0b/%0b/%0h exp=1/1/55", wb_valid, reg_wr, reg_wr_data); end
    ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL stall_flush_count got=%0d exp=%0d", retire_count, exp_cnt); end
    wb_stall = 1'b0;
    tick();
    ncmp++; if (wb_valid !== 1'b0 || reg_wr !== 1'b0) begin nfail++; $display("FAIL flush_drop got=%0b/%0b exp=0/0", wb_valid, reg_wr); end
    ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL flush_count got=%0d exp=%0d", retire_count, exp_cnt); end
    wb_flush = 1'b0;
    mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  dst [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [31:0] val [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, dst[i], val[i], 32'h0, 32'h0);
      tick(); exp_cnt++;
      ncmp++; if (reg_wr !== 1'b1 || reg_wr_addr !== dst[i] || reg_wr_data !== val[i]) begin nfail++; $display("FAIL b2b[%0d] got=%0b/%0d/%0h exp=1/%0d/%0h", i, reg_wr, reg_wr_addr, reg_wr_data, dst[i], val[i]); end
    end
    ncmp++; if (retire_count !== exp_cnt) begin nfail++; $display("FAIL b2b_count got=%0d exp=%0d", retire_count, exp_cnt); end
    mem_valid = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    reset = 1'b1; mem_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 5'd8, 32'(i), 32'h0, 32'h0);
      tick();
    end
    ncmp++; if (retire_count4 !== 4'd1) begin nfail++; $display("FAIL wrap_cnt4 got=%0d exp=1", retire_count4); end
    ncmp++; if (retire_count !== 32'd17) begin nfail++; $display("FAIL wrap_cnt32 got=%0d exp=17", retire_count); end
    ncmp++; if (reg_wr !== 1'b1 || reg_wr_data !== 32'd16) begin nfail++; $display("FAIL pre_reset_entry got=%0b/%0h exp=1/10", reg_wr, reg_wr_data); end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_valid = 1'b0;
    ncmp++; if (reg_wr !== 1'b0 || wb_valid !== 1'b0) begin nfail++; $display("FAIL mid_reset_wr got=%0b/%0b exp=0/0", reg_wr, wb_valid); end
    ncmp++; if (retire_count !== 32'd0 || retire_count4 !== 4'd0) begin nfail++; $display("FAIL mid_reset_count got=%0d/%0d exp=0/0", retire_count, retire_count4); end
  endtask

  initial begin
    exp_cnt = 0;
    test_reset();
    test_alu_write();
    test_load_extract();
    test_link_and_sel3();
    test_misalign();
    test_stall_flush();
    test_back_to_back();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Writeback (WB) stage of the pipelined processor and the driver of the register file's single write port. It captures one completed instruction per cycle from the memory stage and selects the writeback value: ALU result, load data, or link address. For loads it performs byte/halfword extraction with sign or zero extension, then drives `reg_wr`, `reg_wr_addr` and `reg_wr_data` into the decode unit's register file one cycle later. It also flags misaligned loads and counts retired instructions.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; only 32 is supported.
- `ADDR_W`, 5, register address width.
- `CNT_W`, 32, retired-instruction counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `mem_valid`  in  1  memory-stage slot holds a real instruction.
- `mem_reg_wr`  in  1  instruction writes a destination register.
- `mem_wb_sel`  in  2  value select: 00 ALU, 01 load, 10 link (PC+4), 11 treated as ALU.
- `mem_load_type`  in  3  load kind: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes are treated as lw.
- `mem_byte_off`  in  2  load address bits [1:0].
- `mem_dest`  in  ADDR_W  destination register.
- `mem_alu_result`  in  DATA_W  ALU result.
- `mem_rd_data`  in  DATA_W  raw aligned word from data memory.
- `mem_pc_plus4`  in  DATA_W  link value.
- `wb_stall`  in  1  hold the WB register contents.
- `wb_flush`  in  1  discard the incoming memory-stage instruction.
- `reg_wr`  out  1  register-file write enable.
- `reg_wr_addr`  out  ADDR_W  register-file write address.
- `reg_wr_data`  out  DATA_W  register-file write data.
- `wb_valid`  out  1  WB register holds a valid instruction.
- `misalign_err`  out  1  valid load in WB is misaligned; its write is suppressed.
- `retire_count`  out  CNT_W  number of instructions captured into WB.

## Operation
- **WB register.** On each edge without stall, the register loads `valid = mem_valid & ~wb_flush`, plus dest, reg_wr flag, select, load type, offset and the three data inputs. Data fields are don't-care when `valid` is 0.
- **Priority.** `reset` > `wb_stall` > load.
  - Under stall, every field holds.
  - Under simultaneous stall and flush, the register holds and the flush is ignored. The upstream instruction is not consumed.
- **Load extraction.** Little-endian.
  - lb/lbu: byte `rd_data[8*off+7 : 8*off]`, sign-/zero-extended to 32 bits.
  - lh/lhu: halfword `off[1] ? rd_data[31:16] : rd_data[15:0]`, sign-/zero-extended.
  - lw: the whole word.
- **Misalignment.**
  - A load is misaligned for lh/lhu when `off[0]=1`, and for lw when `off≠0`.
  - Misalignment applies only when `wb_sel=01`; ALU and link results ignore `off`.
- **Write-port outputs** (combinational from the WB register):
  - `reg_wr = valid & reg_wr_flag & (dest≠0) & ~misalign`.
  - `reg_wr_addr = dest`.
  - `reg_wr_data` = the selected/extracted value.
- **Register 0.** A write to register 0 never asserts `reg_wr`. The instruction still counts as retired.
- **Error output.** `misalign_err = valid & (wb_sel=01) & misaligned`. It is a level held for as long as the entry sits in WB.
- **Retire counter.** `retire_count` increments by 1 on each edge where `~reset & ~wb_stall & mem_valid & ~wb_flush`. It wraps modulo 2^CNT_W with no saturation.

## Timing
- **Reset values** on the edge where `reset`=1: `valid`=0 and `retire_count`=0. In the following cycle `reg_wr`=0, `wb_valid`=0, `misalign_err`=0, and `reg_wr_addr`=0, `reg_wr_data`=0 (the address and data fields are cleared).
- **Latency.** An instruction presented in cycle N is captured at edge N. `reg_wr` is asserted throughout cycle N+1, and the register file commits it at edge N+1. Throughput is 1 instruction per cycle.
- **Stall.** A stalled entry keeps `reg_wr` asserted, which repeats an idempotent write of the same address and data. It is not recounted.
- **Reset mid-operation.** Reset drops the in-flight WB entry with no write after the reset edge. Upstream is responsible for replay.
- **Combinational paths.** No combinational path from any `mem_*` input to any output. All outputs depend only on the WB register.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles with `mem_valid`=1 → `reg_wr`=0, `wb_valid`=0, `retire_count`=0 throughout and one cycle after release.
- **ALU write:** `mem_valid`=1, `mem_reg_wr`=1, sel=00, dest=7, alu=20 at cycle N → cycle N+1 shows `reg_wr`=1, addr=7, data=20; `retire_count`=1.
- **Load extraction:** `rd_data`=0x8081_F2F3 with dest=4.
  - lb, off=1 → data 0xFFFF_FFF2.
  - lbu, off=3 → 0x0000_0080.
  - lh, off=2 → 0xFFFF_8081.
  - lhu, off=0 → 0x0000_F2F3.
  - lw, off=0 → 0x8081_F2F3.
- **Misalignment and register 0:**
  - lh with off=1, dest=5 → `misalign_err`=1, `reg_wr`=0, count still increments.
  - ALU write to dest=0 → `reg_wr`=0, `misalign_err`=0.
- **Stall and flush:**
  - Capture dest=9 data=0x55, then assert `wb_stall` for 3 cycles while changing inputs → outputs hold dest=9/0x55 with `reg_wr`=1; count unchanged.
  - Stall with flush together → still held.
  - Flush alone with `mem_valid`=1 → next cycle `wb_valid`=0, `reg_wr`=0, count unchanged.
- **Counter wrap and reset mid-stream:**
  - With `CNT_W`=4, 17 back-to-back valid instructions → `retire_count`=1.
  - Assert reset while a valid write sits in WB → next cycle `reg_wr`=0 and count=0.
